// File: rtl/cpc_bus_initiator.sv
// Z80-style expansion-bus initiator: turns single commands into M1, memory and IO
// bus cycles, honours READY wait states and aborts cycles stalled for too long.
module cpc_bus_initiator #(
  parameter int unsigned IO_WAIT  = 1,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_adr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] adr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        m1_b,
  output logic        rfsh_b,
  input  logic        ready
);

  localparam logic [2:0] OpMemRd = 3'b000;
  localparam logic [2:0] OpMemWr = 3'b001;
  localparam logic [2:0] OpIoRd  = 3'b010;
  localparam logic [2:0] OpIoWr  = 3'b011;
  localparam logic [2:0] OpM1    = 3'b100;

  localparam logic [1:0] IoWaitW  = 2'(IO_WAIT);
  localparam logic [7:0] WaitMaxW = 8'(WAIT_MAX);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTa, StTw, StT3, StT4, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [1:0]  tcnt_q, tcnt_d;
  logic [6:0]  r_q, r_d;
  logic        accept, sample, cap, err_d, io_op;
  logic        in_cyc, late;
  logic        mreq_d, iorq_d, rd_d, wr_d, m1_d, rfsh_d, oe_d;
  logic [15:0] adr_d;

  assign io_op = (op_q[2:1] == 2'b01);

  // Next-state: command accept, IO auto-waits, READY sampling and watchdog abort
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    r_d     = r_q;
    accept  = 1'b0;
    sample  = 1'b0;
    cap     = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (cmd_valid) begin
          accept = 1'b1;
          op_d   = cmd_op;
          if (cmd_op > OpM1) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StT1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StT1: begin
        state_d = StT2;
        wcnt_d  = 8'd0;
        tcnt_d  = 2'd0;
      end
      StT2: begin
        if (io_op && IoWaitW != 2'd0) begin
          state_d = StTa;
          tcnt_d  = 2'd1;
        end else begin
          sample = 1'b1;
        end
      end
      StTa: begin
        if (tcnt_q == IoWaitW) sample = 1'b1;
        else tcnt_d = tcnt_q + 2'd1;
      end
      StTw: begin
        if (ready) begin
          state_d = StT3;
          cap     = (op_q == OpM1);
        end else if (wcnt_q == WaitMaxW) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      StT3: begin
        state_d = (op_q == OpM1) ? StT4 : StDone;
        cap     = (op_q == OpMemRd) || (op_q == OpIoRd);
      end
      StT4: begin
        state_d = StDone;
        r_d     = r_q + 7'd1;
      end
      default: state_d = StIdle;
    endcase
    if (sample) begin
      if (ready) begin
        state_d = StT3;
        cap     = (op_q == OpM1);
      end else begin
        state_d = StTw;
        wcnt_d  = 8'd1;
      end
    end
  end

  // Strobe decode from the upcoming state so every bus output comes straight from a flop
  always_comb begin
    mreq_d = 1'b1;
    iorq_d = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    m1_d   = 1'b1;
    rfsh_d = 1'b1;
    oe_d   = 1'b0;
    in_cyc = state_d inside {StT1, StT2, StTa, StTw, StT3};
    late   = state_d inside {StT2, StTa, StTw, StT3};
    case (op_d)
      OpMemRd: if (in_cyc) begin
        mreq_d = 1'b0;
        rd_d   = 1'b0;
      end
      OpMemWr: begin
        if (in_cyc) begin
          mreq_d = 1'b0;
          oe_d   = 1'b1;
        end
        if (late) wr_d = 1'b0;
      end
      OpIoRd: if (late) begin
        iorq_d = 1'b0;
        rd_d   = 1'b0;
      end
      OpIoWr: begin
        if (in_cyc) oe_d = 1'b1;
        if (late) begin
          iorq_d = 1'b0;
          wr_d   = 1'b0;
        end
      end
      OpM1: begin
        if (state_d inside {StT1, StT2, StTw}) begin
          m1_d   = 1'b0;
          mreq_d = 1'b0;
          rd_d   = 1'b0;
        end else if (state_d == StT3) begin
          rfsh_d = 1'b0;
        end else if (state_d == StT4) begin
          mreq_d = 1'b0;
          rfsh_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Refresh cycles put the 7-bit refresh counter on the low address byte
    if (accept && state_d == StT1)                          adr_d = cmd_adr;
    else if (op_d == OpM1 && state_d inside {StT3, StT4}) adr_d = {8'h00, 1'b0, r_q};
    else                                                    adr_d = adr;
  end

  // State and registered outputs; reset releases the bus asynchronously
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= StIdle;
      op_q      <= 3'b000;
      wcnt_q    <= 8'd0;
      tcnt_q    <= 2'd0;
      r_q       <= 7'd0;
      mreq_b    <= 1'b1;
      iorq_b    <= 1'b1;
      rd_b      <= 1'b1;
      wr_b      <= 1'b1;
      m1_b      <= 1'b1;
      rfsh_b    <= 1'b1;
      data_oe   <= 1'b0;
      adr       <= 16'h0000;
      data_out  <= 8'h00;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      r_q       <= r_d;
      mreq_b    <= mreq_d;
      iorq_b    <= iorq_d;
      rd_b      <= rd_d;
      wr_b      <= wr_d;
      m1_b      <= m1_d;
      rfsh_b    <= rfsh_d;
      data_oe   <= oe_d;
      adr       <= adr_d;
      cmd_ready <= (state_d == StIdle) || (state_d == StDone);
      rsp_valid <= (state_d == StDone);
      rsp_err   <= err_d;
      if (accept && (cmd_op == OpMemWr || cmd_op == OpIoWr)) data_out <= cmd_wdata;
      if (cap) rsp_rdata <= data_in;
    end
  end

endmodule

// File: doc/cpc_bus_initiator.md
# cpc_bus_initiator

Bus-cycle initiator for CPC expansion-card bring-up and test benches. It is the driving end of the Z80 expansion bus that the RAM expansion CPLD responds to. Single commands are accepted on a valid/ready interface and turned into Z80-style M1 fetch, memory read/write and IO read/write cycles on mreq_b/iorq_b/rd_b/wr_b/m1_b/rfsh_b, honouring READY wait states. A watchdog aborts any cycle that is stalled too long.

## Interface
- IO_WAIT, 1: automatic wait states inserted in every IO cycle before READY is sampled (0..3).
- WAIT_MAX, 255: maximum READY-low wait states before abort (1..255).
- clk  in  1  bus clock; one clk period = one T-state; all state changes on posedge.
- reset_b  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready on posedge.
- cmd_op  in  3  000 mem read, 001 mem write, 010 IO read, 011 IO write, 100 M1 fetch; 101-111 illegal.
- cmd_adr  in  16  cycle address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse at command completion.
- rsp_rdata  out  8  captured read data; holds until the next read completes.
- rsp_err  out  1  qualified by rsp_valid: timeout or illegal op.
- adr  out  16  bus address.
- data_out  out  8  write data; data_oe  out  1  data bus drive enable.
- data_in  in  8  bus read data.
- mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b  out  1 each  active-low bus strobes.
- ready  in  1  high = proceed, low = insert wait state.

## Operation
- States: IDLE, T1, T2, TA (auto IO wait), TW, T3, T4, DONE.
- IDLE: cmd_ready=1, all strobes 1, data_oe=0. On accept, latch op/adr/wdata and go to T1. Illegal op goes to DONE with err=1 and no bus activity.
- adr = latched cmd_adr from T1 through T3. Exception: during M1 T3/T4, adr = {8'h00, 1'b0, r_q[6:0]}.
- Mem read: T1 and T2 assert mreq_b=0, rd_b=0. At end of T2, ready=0 goes to TW and ready=1 goes to T3. TW repeats while ready=0. Strobes stay low through T3. Data is captured from data_in at the edge leaving T3.
- Mem write: data_oe=1 from T1 through T3. mreq_b=0 T1..T3. wr_b=0 T2..T3 (not T1).
- IO read/write: T1 has adr only. iorq_b=0 and rd_b or wr_b=0 from T2 through T3. IO_WAIT TA states follow T2; ready is sampled at the end of the last TA (or T2 if IO_WAIT=0). IO write drives data_oe from T1.
- M1: m1_b=0, mreq_b=0, rd_b=0 in T1..T2/TW. Data is captured at the edge leaving the last T2/TW (ready=1).
- M1 refresh: T3 has m1_b=1, rd_b=1, mreq_b=1, rfsh_b=0. T4 has mreq_b=0, rfsh_b=0. r_q (7-bit) increments at the end of T4, wrapping 127 to 0.
- Watchdog: a counter of consecutive TW states, cleared on T1. If the counter reaches WAIT_MAX while ready=0, go to DONE with err=1, release all strobes and data_oe immediately, and do not update rsp_rdata.
- DONE: rsp_valid=1 for one clk, cmd_ready=1. An accept in DONE goes straight to T1, so back-to-back cycles have exactly one idle T-state between them.
- cmd_valid while cmd_ready=0 is ignored; the command inputs must be held by the sender until accepted.

## Timing
- Reset values: all strobes 1, data_oe=0, adr=0, data_out=0, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, r_q=0.
- Reset mid-cycle: strobes release asynchronously; no rsp_valid is produced for the aborted command.
- Zero-wait lengths: mem read/write = 3 clk of mreq_b low. IO = 2+IO_WAIT clk of iorq_b low. M1 = 2 clk mreq_b low, then 1 clk high, then 1 clk low for refresh.
- Each TW adds exactly 1 clk.
- Latency from accept edge to rsp_valid: mem 4+n clk, IO 4+IO_WAIT+n clk, M1 5+n clk (n = wait states).
- All outputs are registered, so there are no glitches on the strobes.

## Test plan
- Mem read 0x4000 with ready=1 and data_in=0xA5: mreq_b/rd_b low for 3 clk, rsp_valid 4 clk after accept, rsp_rdata=0xA5, rsp_err=0.
- Mem write 0xC123 with 0x5A and ready low for 2 clk in T2: mreq_b low 5 clk, wr_b low 4 clk, data_oe high 5 clk with data_out=0x5A.
- IO write 0x7F00 with data 0xC2 and IO_WAIT=1: iorq_b and wr_b low 3 clk starting at T2, m1_b and mreq_b stay 1.
- 130 back-to-back M1 fetches: refresh address low byte runs 0x00..0x7F then 0x00 and 0x01; rfsh_b low 2 clk per fetch; one idle clk between fetches.
- Ready held low with WAIT_MAX=4: abort after 4 TW, rsp_err=1, strobes released, rsp_rdata unchanged; the next command runs normally.
- reset_b asserted during TW of a write: strobes high and data_oe=0 immediately; no rsp_valid; after release, cmd_ready=1 and r_q=0.
